// File: rtl/dct_pkg.sv
// dct_pkg
// Shared definitions for the DCT transpose buffer:
//   - default block dimension and coefficient width
//   - bank-state enum, used to derive the stream handshake flags and
//     visible in waveforms for debug
//   - lane_lsb(): bit offset of a W-bit lane inside an N*W-bit beat
package dct_pkg;

  localparam int DCT_N_DEF = 8;
  localparam int DCT_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/dct_transpose_bank.sv
// dct_transpose_bank
// One N x N register bank of W-bit coefficients.
// Ports:
//   i_clk    clock, rising edge
//   i_srst   synchronous active-high reset, clears every element
//   i_we     row write enable
//   i_row    row index for the write
//   i_wdata  N*W row data, lane c at bits [c*W +: W]
//   i_col    column index for the read
//   o_cdata  N*W column data, lane r = element [r][i_col] (combinational)
module dct_transpose_bank
  import dct_pkg::*;
#(
  parameter int N  = DCT_N_DEF,
  parameter int W  = DCT_W_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_srst,
  input  logic            i_we,
  input  logic [IW-1:0]   i_row,
  input  logic [N*W-1:0]  i_wdata,
  input  logic [IW-1:0]   i_col,
  output logic [N*W-1:0]  o_cdata
);

  // Each row lives in its own generate scope; the same scope drives
  // lane gi of the column read, since lane r of a column is row r.
  for (genvar gi = 0; gi < N; gi++) begin : gen_row
    logic [N*W-1:0] r_row;

    always_ff @(posedge i_clk) begin
      if (i_srst) begin
        r_row <= '0;
      end else if (i_we && (i_row == IW'(gi))) begin
        r_row <= i_wdata;
      end
    end

    assign o_cdata[lane_lsb(gi, W) +: W] = r_row[i_col*W +: W];
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer
// Ping-pong N x N transpose buffer: rows in, columns out. One bank fills
// while the other drains, so the stream runs at one beat per cycle.
// Ports:
//   ACLK     clock, rising edge
//   ARESET   synchronous active-high reset
//   s_valid / s_ready / s_data / s_last   input row stream
//   m_valid / m_ready / m_data / m_last   output column stream
//   err      sticky: s_last disagreed with the internal row counter
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int N = DCT_N_DEF,
  parameter int W = DCT_W_DEF
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N*W-1:0]  s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N*W-1:0]  m_data,
  output logic            m_last,
  output logic            err
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [IW-1:0] r_wr_row;
  logic [IW-1:0] r_rd_col;
  logic [1:0]    r_full;
  logic          r_err;

  bank_state_e    w_state [2];
  logic [N*W-1:0] w_bank_data [2];
  logic           w_s_ready;
  logic           w_m_valid;
  logic           w_wr_fire;
  logic           w_rd_fire;
  logic           w_wr_last;
  logic           w_rd_last;
  logic [1:0]     w_full_set;
  logic [1:0]     w_full_clr;

  // Bank state is derived from the full flags and pointers; no extra state.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_bank
    assign w_state[gi] =
      r_full[gi] ? (((r_rd_bank == 1'(gi)) && (r_rd_col != '0)) ? DRAINING : FULL)
                 : (((r_wr_bank == 1'(gi)) && (r_wr_row != '0)) ? FILLING  : EMPTY);

    dct_transpose_bank #(
      .N  (N),
      .W  (W),
      .IW (IW)
    ) u_bank (
      .i_clk   (ACLK),
      .i_srst  (ARESET),
      .i_we    (w_wr_fire && (r_wr_bank == 1'(gi))),
      .i_row   (r_wr_row),
      .i_wdata (s_data),
      .i_col   (r_rd_col),
      .o_cdata (w_bank_data[gi])
    );
  end

  assign w_s_ready = !ARESET && ((w_state[r_wr_bank] == EMPTY) ||
                                 (w_state[r_wr_bank] == FILLING));
  assign w_m_valid = (w_state[r_rd_bank] == FULL) ||
                     (w_state[r_rd_bank] == DRAINING);

  assign w_wr_fire = s_valid && w_s_ready;
  assign w_rd_fire = w_m_valid && m_ready;
  assign w_wr_last = (r_wr_row == LAST_IDX);
  assign w_rd_last = (r_rd_col == LAST_IDX);

  // Set and clear can never hit the same bank in one cycle: a set needs
  // the write bank non-full, a clear needs the read bank full.
  assign w_full_set = (w_wr_fire && w_wr_last) ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_full_clr = (w_rd_fire && w_rd_last) ? (2'b01 << r_rd_bank) : 2'b00;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_row  <= '0;
      r_rd_col  <= '0;
      r_full    <= 2'b00;
      r_err     <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_row  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_row <= r_wr_row + 1'b1;
        end
        // Row counter is authoritative; a bad s_last only flags.
        if (s_last != w_wr_last) begin
          r_err <= 1'b1;
        end
      end
      if (w_rd_fire) begin
        if (w_rd_last) begin
          r_rd_col  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_col <= r_rd_col + 1'b1;
        end
      end
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = w_m_valid;
  assign m_data  = r_rd_bank ? w_bank_data[1] : w_bank_data[0];
  assign m_last  = w_m_valid && w_rd_last;
  assign err     = r_err;

endmodule

// File: doc/dct_transpose_buffer.md
# dct_transpose_buffer

Ping-pong N×N transpose buffer between the row (first) 1-D DCT pass and the column (second) pass of the DCT_Kernel datapath. Accepts one row of N signed coefficients per beat on a valid/ready stream and emits the same block one column per beat. While one bank drains, the other fills, so sustained throughput is one beat per cycle with no bubbles.

## Interface
- N, 8, block dimension (rows = columns = lanes per beat); 4, 8, 16 or 32
- W, 16, coefficient width in bits (two's complement, passed through unmodified)
- ACLK  in  1  sole clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- s_valid  in  1  input row beat valid
- s_ready  out  1  buffer can accept an input row
- s_data  in  N*W  row r, lane c = x[r][c] at bits [c*W +: W]
- s_last  in  1  upstream marks row N-1 of a block
- m_valid  out  1  output column beat valid
- m_ready  in  1  downstream accepts column
- m_data  out  N*W  column c, lane r = x[r][c] at bits [r*W +: W]
- m_last  out  1  high on column N-1 of a block
- err  out  1  sticky: s_last disagreed with internal row count

## Operation
- Two banks B0/B1, each N×N×W flops, each with a full flag. Write pointer: wr_bank, wr_row (0..N-1). Read pointer: rd_bank, rd_col (0..N-1).
- Per-bank state: EMPTY -> FILLING (first row accepted) -> FULL (row N-1 accepted) -> DRAINING (first column accepted) -> EMPTY (column N-1 accepted).
- Input handshake s_valid&s_ready: write s_data into bank[wr_bank] row wr_row; wr_row++; on wr_row==N-1 set full[wr_bank], wr_row=0, toggle wr_bank.
- s_ready = !ARESET & !full[wr_bank].
- m_valid = full[rd_bank]; m_data = column rd_col of bank[rd_bank], combinational from bank flops; m_last = m_valid & (rd_col==N-1).
- Output handshake m_valid&m_ready: rd_col++; on rd_col==N-1 clear full[rd_bank], rd_col=0, toggle rd_bank.
- Internal row counter is authoritative: if s_last != (wr_row==N-1) on an accepted beat, set err; beat still written normally. err cleared only by reset.
- Write to bank X and drain of bank Y≠X in the same cycle are independent. Write and drain never target the same bank (full flag guards).
- Holding m_valid: once asserted, m_valid and m_data stay stable until handshake (AXI-Stream rule); s_valid may be deasserted at any time without penalty.

## Timing
- Reset (ARESET high at an edge): wr_bank=rd_bank=0, wr_row=rd_col=0, full=00, err=0, all bank flops 0. Outputs during and after reset: s_ready=0 while ARESET high, 1 the first cycle after; m_valid=0, m_last=0, m_data=0, err=0.
- Reset mid-block discards both banks' contents; no partial block is emitted.
- Latency: row N-1 accepted at edge t -> m_valid high in cycle t+1 with column 0.
- Bank release: column N-1 accepted at edge t -> full cleared, s_ready for that bank high in cycle t+1 (no same-cycle ready-through).
- Sustained: continuous s_valid and m_ready give 1 beat/cycle in and out; first output N cycles after first input.
- Both banks full: s_ready=0 until a drain completes.

## Structure
- dct_pkg: defaults for N and W, bank-state enum (EMPTY, FILLING, FULL, DRAINING) for debug visibility, lane-slice helper function.
- Sub-module dct_transpose_bank: one N×N register bank, synchronous row write port (we, row index, N*W data), combinational column read port (column index -> N*W data); instantiated twice, top holds pointers, flags and muxes.

## Test plan
- Single block N=8, W=16, x[r][c]=16'(r*8+c), m_ready=1 -> 8 columns, column c lane r = r*8+c; m_last only on 8th; m_valid rises one cycle after 8th input beat.
- Back-to-back 4 blocks, s_valid and m_ready held high -> no bubbles: s_ready never drops, 32 output beats in 32 consecutive cycles after the first 8.
- m_ready held low after two blocks written -> s_ready drops after 16th beat; raising m_ready for 8 beats -> s_ready high exactly one cycle after 8th column handshake; m_data stable while stalled.
- s_last asserted on row 3 of a block -> err=1 from next cycle and stays 1; block still emitted correctly transposed.
- Reset asserted after 5 rows written -> s_ready=0, m_valid=0 during reset; next 8 rows form a fresh block, output matches only new data. Signed extremes (16'h8000, 16'h7FFF) pass through bit-exact.
